// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO write arbiter.
// Defines a fallback `WIDTH so the data width default is always resolvable.
`ifndef WIDTH
`define WIDTH 8
`endif

package fifo_arb_pkg;

  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned DefMaxBurst = 4;
  localparam int unsigned BurstW      = 8;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  // Owner index width; a single requester still needs one bit.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first requester after last_owner_i, wrapping.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned IdxW   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    last_owner_i,
  output logic [IdxW-1:0]    owner_o,
  output logic               valid_o
);

  int unsigned idx;

  always_comb begin
    owner_o = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner_i) + k) % NUM_REQ;
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        owner_o = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_STATS_EN to add per-requester accepted-beat counters (beat_cnt_o).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned WIDTH     = `WIDTH,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  input  logic                     full_i,
  input  logic                     wr_error_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     wr_en_o,
  output logic [WIDTH-1:0]         wdata_o,
  output logic                     busy_o,
`ifdef FIFO_ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]    beat_cnt_o,
`endif
  output logic                     err_o
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_owner_q, last_owner_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              err_q, err_d;

  logic [IdxW-1:0]   pick_owner;
  logic              pick_valid;
  logic              beat;
  logic [BurstW-1:0] burst_inc;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req_i        (req_i),
    .last_owner_i (last_owner_q),
    .owner_o      (pick_owner),
    .valid_o      (pick_valid)
  );

  assign beat      = (state_q == StGrant) && req_i[owner_q] && !full_i;
  assign burst_inc = burst_q + BurstW'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_d      = burst_q;
    err_d        = err_q | wr_error_i;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StGrant;
          owner_d = pick_owner;
          burst_d = '0;
        end
      end
      StGrant: begin
        // A dropped request ends the grant immediately; full_i alone just stalls.
        if (!req_i[owner_q]) begin
          state_d      = StIdle;
          last_owner_d = owner_q;
        end else if (beat) begin
          burst_d = burst_inc;
          if (burst_inc == BurstW'(MAX_BURST)) begin
            state_d      = StIdle;
            last_owner_d = owner_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      last_owner_q <= IdxW'(NUM_REQ - 1);
      burst_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_q      <= burst_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    gnt_o   = '0;
    wdata_o = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (beat && (owner_q == IdxW'(i))) begin
        gnt_o[i] = 1'b1;
        wdata_o  = wdata_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign wr_en_o = beat;
  assign busy_o  = (state_q == StGrant);
  assign err_o   = err_q;

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [15:0] cnt_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (gnt_o[g]) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign beat_cnt_o[g*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (default parameters).
`ifndef WIDTH
`define WIDTH 8
`endif

module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = `WIDTH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*W-1:0]   wdata;
  logic              full = 1'b0;
  logic              werr = 1'b0;
  logic [NR-1:0]     gnt;
  logic              wr_en;
  logic [W-1:0]      wdo;
  logic              busy;
  logic              err;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0]  beat_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [NR+W+1:0] got, want;

  always #5 clk = ~clk;

  fifo_wr_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .wdata_i    (wdata),
    .full_i     (full),
    .wr_error_i (werr),
    .gnt_o      (gnt),
    .wr_en_o    (wr_en),
    .wdata_o    (wdo),
    .busy_o     (busy),
`ifdef FIFO_ARB_STATS_EN
    .beat_cnt_o (beat_cnt),
`endif
    .err_o      (err)
  );

  function automatic logic [W-1:0] dat(int k);
    return W'(32'hA1 + 32'h11 * k);
  endfunction

  // Expected {gnt, wr_en, wdata, busy} for a given grant vector and busy state.
  function automatic logic [NR+W+1:0] expv(logic [NR-1:0] g, logic b);
    logic [W-1:0] d;
    d = '0;
    for (int k = 0; k < int'(NR); k++) if (g[k]) d = dat(k);
    return {g, |g, d, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    full = 1'b0;
    werr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    got = {gnt, wr_en, wdo, busy};
    want = expv('0, 1'b0);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", got, want);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_err: got %b want 0", err);
    end
  endtask

  task automatic test_single();
    logic [NR-1:0] eg [7];
    eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      #1;
      got = {gnt, wr_en, wdo, busy};
      want = expv(eg[c], |eg[c]);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL single_cyc%0d: got %h want %h", c, got, want);
      end
      step();
    end
    req = '0;
  endtask

  task automatic test_all();
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      got = {gnt, wr_en, wdo, busy};
      want = expv('0, 1'b0);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL all_idle_g%0d: got %h want %h", g, got, want);
      end
      step();
      for (int b = 0; b < 4; b++) begin
        #1;
        got = {gnt, wr_en, wdo, busy};
        want = expv(NR'(1 << (g % 4)), 1'b1);
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL all_g%0d_b%0d: got %h want %h", g, b, got, want);
        end
        step();
      end
    end
    req = '0;
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      // 1 idle, 2 beats, 5 stalled, 2 beats, 1 idle, then owner 3
      logic [NR-1:0] g;
      logic          b;
      if (c == 3) begin
        full = 1'b1;
        req  = 4'b1111;
      end
      if (c == 8) full = 1'b0;
      g = (c inside {[1:2], [8:9]}) ? 4'b0100 : (c == 11) ? 4'b1000 : 4'b0000;
      b = !(c == 0 || c == 10);
      #1;
      got = {gnt, wr_en, wdo, busy};
      want = expv(g, b);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL stall_cyc%0d: got %h want %h", c, got, want);
      end
      step();
    end
    req = '0;
  endtask

  task automatic test_drop();
    logic [NR-1:0] eg [5];
    logic          eb [5];
    eg = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1000};
    eb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    req = 4'b1001;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) req = 4'b1000;
      #1;
      got = {gnt, wr_en, wdo, busy};
      want = expv(eg[c], eb[c]);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL drop_cyc%0d: got %h want %h", c, got, want);
      end
      step();
    end
    req = '0;
  endtask

  task automatic test_err_reset();
    do_reset();
    werr = 1'b1;
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_before: got %b want 0", err);
    end
    step();
    werr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if (err !== 1'b1) begin
        n_bad++;
        $display("FAIL err_sticky_cyc%0d: got %b want 1", c, err);
      end
      step();
    end
    req = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      got = {gnt, wr_en, wdo, busy};
      want = (c == 0) ? expv('0, 1'b0) : expv(4'b0010, 1'b1);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL midburst_cyc%0d: got %h want %h", c, got, want);
      end
      if (c == 2) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    req = 4'b0011;
    #1;
    got = {gnt, wr_en, wdo, busy, err};
    want = {expv('0, 1'b0), 1'b0};
    n_cmp++;
    if ({got, 1'b0} !== {want, 1'b0} || err !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset: got %h err %b want %h err 0", got, err, want);
    end
    step();
    #1;
    got = {gnt, wr_en, wdo, busy};
    want = expv(4'b0001, 1'b1);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL first_after_reset: got %h want %h", got, want);
    end
    step();
    req = '0;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    logic [NR*16-1:0] exp_cnt;
    exp_cnt = '0;
    exp_cnt[16 +: 16] = 16'd10;
    do_reset();
    req = 4'b0010;
    // idle, 4 beats, idle, 4 beats, idle, 2 beats
    repeat (13) step();
    req = '0;
    #1;
    n_cmp++;
    if (beat_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL stats_count: got %h want %h", beat_cnt, exp_cnt);
    end
    step();
  endtask
`endif

  initial begin
    for (int k = 0; k < int'(NR); k++) wdata[k*W +: W] = dat(k);
    test_reset();
    test_single();
    test_all();
    test_stall();
    test_drop();
    test_err_reset();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
